// File: rtl/arith_pkg.sv
// Shared arithmetic-library definitions: FSM state encoding and default operand width.
package arith_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam int DEFAULT_WIDTH = 8;

endpackage

// File: rtl/fa_by_ha.sv
// One-bit full adder built from two half adders and an OR for the carry.
module fa_by_ha (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    logic ha0_s;
    logic ha0_c;
    logic ha1_c;

    assign ha0_s = a ^ b;
    assign ha0_c = a & b;
    assign s     = ha0_s ^ ci;
    assign ha1_c = ha0_s & ci;
    assign co    = ha0_c | ha1_c;

endmodule

// File: rtl/serial_adder_fa.sv
// Bit-serial LSB-first adder: sum = a + b + cin over WIDTH cycles through one full-adder cell.
module serial_adder_fa
    import arith_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic [1:0]       state_dbg
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] CNT_PEN  = CW'(WIDTH - 2);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    // Handshake: start is accepted on any edge where the block is not in RUN
    // (IDLE or DONE); operands are captured on that edge. done is a one-cycle
    // pulse, and sum/cout/ovf then hold until the next accepted start.

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic             carry_q, carry_d;
    logic             c_msb_in_q, c_msb_in_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;

    logic fa_s;
    logic fa_co;
    logic accept;

    fa_by_ha u_cell (
        .a  (a_sh_q[0]),
        .b  (b_sh_q[0]),
        .ci (carry_q),
        .s  (fa_s),
        .co (fa_co)
    );

    assign accept = start && (state_q != ST_RUN);

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        a_sh_d     = a_sh_q;
        b_sh_d     = b_sh_q;
        carry_d    = carry_q;
        c_msb_in_d = c_msb_in_q;
        sum_d      = sum_q;
        cout_d     = cout_q;
        ovf_d      = ovf_q;
        if (accept) begin
            a_sh_d     = a;
            b_sh_d     = b;
            carry_d    = cin;
            cnt_d      = '0;
            c_msb_in_d = 1'b0;
            sum_d      = '0;
            cout_d     = 1'b0;
            ovf_d      = 1'b0;
            state_d    = ST_RUN;
        end else begin
            case (state_q)
                ST_RUN: begin
                    sum_d   = {fa_s, sum_q[WIDTH-1:1]};
                    a_sh_d  = a_sh_q >> 1;
                    b_sh_d  = b_sh_q >> 1;
                    carry_d = fa_co;
                    cnt_d   = cnt_q + CW'(1);
                    // Carry out of bit WIDTH-2 is the carry entering the MSB.
                    if (cnt_q == CNT_PEN) begin
                        c_msb_in_d = fa_co;
                    end
                    if (cnt_q == CNT_LAST) begin
                        cout_d  = fa_co;
                        ovf_d   = fa_co ^ c_msb_in_q;
                        state_d = ST_DONE;
                    end
                end
                ST_DONE: state_d = ST_IDLE;
                ST_IDLE: state_d = ST_IDLE;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            a_sh_q     <= '0;
            b_sh_q     <= '0;
            carry_q    <= 1'b0;
            c_msb_in_q <= 1'b0;
            sum_q      <= '0;
            cout_q     <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            a_sh_q     <= a_sh_d;
            b_sh_q     <= b_sh_d;
            carry_q    <= carry_d;
            c_msb_in_q <= c_msb_in_d;
            sum_q      <= sum_d;
            cout_q     <= cout_d;
            ovf_q      <= ovf_d;
        end
    end

    assign busy      = (state_q == ST_RUN);
    assign done      = (state_q == ST_DONE);
    assign sum       = sum_q;
    assign cout      = cout_q;
    assign ovf       = ovf_q;
    assign state_dbg = state_q;

endmodule
